// File: rtl/spi_pkg.sv
// Shared types and constants for the burst SPI slave.
package spi_pkg;

  // Transfer phase: command word, write burst, read burst
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } spi_state_e;

  // Command word MSB encoding
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Word shifted out when the fabric has not answered in time (cast down to BYTE_W)
  localparam logic [31:0] UNDERRUN_FILL = 32'hFFFF_FFFF;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_pad_sync.sv
// Pad synchroniser and SCK edge detector; yields sample/shift strobes for the
// selected CPOL/CPHA mode. All outputs are registered and aligned with each other.
module spi_pad_sync #(
  parameter int unsigned CPOL = 0,
  parameter int unsigned CPHA = 0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic csn_pad,
  input  logic sck_pad,
  input  logic mosi_pad,
  output logic cs_active,
  output logic sample_en,
  output logic shift_en,
  output logic mosi_s
);

  localparam bit CPOL_B = (CPOL != 0);
  localparam bit CPHA_B = (CPHA != 0);

  logic [1:0] csn_sync_q;
  logic [1:0] sck_sync_q;
  logic [1:0] mosi_sync_q;
  logic       sck_hist_q;
  logic       mosi_q;
  logic       armed_q;
  logic       cs_active_q;
  logic       sample_q;
  logic       shift_q;

  logic rise_c;
  logic fall_c;
  logic lead_c;
  logic trail_c;

  // Edge classification from synchronised SCK and its one-cycle history
  always_comb begin
    rise_c  = sck_sync_q[1] & ~sck_hist_q;
    fall_c  = ~sck_sync_q[1] & sck_hist_q;
    lead_c  = CPOL_B ? fall_c : rise_c;
    trail_c = CPOL_B ? rise_c : fall_c;
  end

  // Synchronisers, history FF and registered strobes. CS sync resets to
  // "asserted" and must see CS high once (armed) so that a reset taken while
  // CS is low never looks like a fresh CS fall.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csn_sync_q  <= '0;
      sck_sync_q  <= {2{CPOL_B}};
      mosi_sync_q <= '0;
      sck_hist_q  <= CPOL_B;
      mosi_q      <= 1'b0;
      armed_q     <= 1'b0;
      cs_active_q <= 1'b0;
      sample_q    <= 1'b0;
      shift_q     <= 1'b0;
    end else begin
      csn_sync_q  <= {csn_sync_q[0], csn_pad};
      sck_sync_q  <= {sck_sync_q[0], sck_pad};
      mosi_sync_q <= {mosi_sync_q[0], mosi_pad};
      sck_hist_q  <= sck_sync_q[1];
      mosi_q      <= mosi_sync_q[1];
      armed_q     <= armed_q | csn_sync_q[1];
      cs_active_q <= armed_q & ~csn_sync_q[1];
      sample_q    <= CPHA_B ? trail_c : lead_c;
      shift_q     <= CPHA_B ? lead_c : trail_c;
    end
  end

  assign cs_active = cs_active_q;
  assign sample_en = sample_q;
  assign shift_en  = shift_q;
  assign mosi_s    = mosi_q;

endmodule

// File: rtl/spi_slave_burst.sv
// Burst SPI slave: command/address word followed by write or read data words
// exchanged with a register-file port. Optional macro SPI_ADDR_AUTOINC_EN makes
// the address advance per data word; otherwise it stays at the start address.
module spi_slave_burst
  import spi_pkg::*;
#(
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CPOL   = 0,
  parameter int unsigned CPHA   = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              csn_pad,
  input  logic              sck_pad,
  input  logic              mosi_pad,
  output logic              miso_pad,
  output logic              busy,
  output logic              wr_valid,
  output logic [ADDR_W-2:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-2:0] rd_addr,
  input  logic              rd_valid,
  input  logic [BYTE_W-1:0] rd_data,
  output logic              rd_underrun
);

  localparam int unsigned AW    = ADDR_W - 1;
  localparam int unsigned SR_W  = max_u(BYTE_W, ADDR_W);
  localparam int unsigned CNT_W = (SR_W > 1) ? $clog2(SR_W) : 1;

  logic cs_active;
  logic sample_en;
  logic shift_en;
  logic mosi_s;

  spi_state_e        state_q,       state_d;
  logic [CNT_W-1:0]  bit_cnt_q,     bit_cnt_d;
  logic [SR_W-1:0]   rx_sr_q,       rx_sr_d;
  logic [BYTE_W-1:0] tx_sr_q,       tx_sr_d;
  logic [AW-1:0]     addr_q,        addr_d;
  logic [BYTE_W-1:0] rd_buf_q,      rd_buf_d;
  logic              rd_have_q,     rd_have_d;
  logic              rd_pend_q,     rd_pend_d;
  logic              miso_q,        miso_d;
  logic              busy_q,        busy_d;
  logic              wr_valid_q,    wr_valid_d;
  logic [AW-1:0]     wr_addr_q,     wr_addr_d;
  logic [BYTE_W-1:0] wr_data_q,     wr_data_d;
  logic              rd_req_q,      rd_req_d;
  logic [AW-1:0]     rd_addr_q,     rd_addr_d;
  logic              rd_underrun_q, rd_underrun_d;
  logic [AW-1:0]     addr_next_c;

  spi_pad_sync #(
    .CPOL (CPOL),
    .CPHA (CPHA)
  ) u_pad_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .csn_pad   (csn_pad),
    .sck_pad   (sck_pad),
    .mosi_pad  (mosi_pad),
    .cs_active (cs_active),
    .sample_en (sample_en),
    .shift_en  (shift_en),
    .mosi_s    (mosi_s)
  );

  // Address used for the word after the current one
  always_comb begin
`ifdef SPI_ADDR_AUTOINC_EN
    addr_next_c = addr_q + AW'(1);
`else
    addr_next_c = addr_q;
`endif
  end

  // State and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      addr_q        <= '0;
      rd_buf_q      <= '0;
      rd_have_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      miso_q        <= 1'b0;
      busy_q        <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= '0;
      rd_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      addr_q        <= addr_d;
      rd_buf_q      <= rd_buf_d;
      rd_have_q     <= rd_have_d;
      rd_pend_q     <= rd_pend_d;
      miso_q        <= miso_d;
      busy_q        <= busy_d;
      wr_valid_q    <= wr_valid_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rd_req_q      <= rd_req_d;
      rd_addr_q     <= rd_addr_d;
      rd_underrun_q <= rd_underrun_d;
    end
  end

  // Next-state, shifting, handshakes and registered-output next values
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    addr_d        = addr_q;
    rd_buf_d      = rd_buf_q;
    rd_have_d     = rd_have_q;
    rd_pend_d     = rd_pend_q;
    wr_valid_d    = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    rd_req_d      = 1'b0;
    rd_addr_d     = rd_addr_q;
    rd_underrun_d = 1'b0;

    // Capture read return only while a request is outstanding
    if (rd_pend_q && rd_valid) begin
      rd_buf_d  = rd_data;
      rd_have_d = 1'b1;
      rd_pend_d = 1'b0;
    end

    if ((state_q != ST_IDLE) && !cs_active) begin
      // CS released: drop partial word and any prefetched data
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      tx_sr_d   = '0;
      rd_have_d = 1'b0;
      rd_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_active) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
            tx_sr_d   = '0;
            rd_have_d = 1'b0;
            rd_pend_d = 1'b0;
          end
        end

        ST_CMD: begin
          if (sample_en) begin
            rx_sr_d = (rx_sr_q << 1) | SR_W'(mosi_s);
            if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
              bit_cnt_d = '0;
              addr_d    = rx_sr_d[AW-1:0];
              if (rx_sr_d[AW] == RW_READ) begin
                state_d   = ST_RD;
                rd_req_d  = 1'b1;
                rd_addr_d = rx_sr_d[AW-1:0];
                rd_pend_d = 1'b1;
                rd_have_d = 1'b0;
              end else begin
                state_d = ST_WR;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end

        ST_WR: begin
          if (sample_en) begin
            rx_sr_d = (rx_sr_q << 1) | SR_W'(mosi_s);
            if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
              bit_cnt_d  = '0;
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = rx_sr_d[BYTE_W-1:0];
              addr_d     = addr_next_c;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end

        ST_RD: begin
          if (shift_en) begin
            if (bit_cnt_q == '0) begin
              // Word boundary: load prefetched word (or fill) and prefetch the next
              if (rd_have_q) begin
                tx_sr_d = rd_buf_q;
              end else begin
                tx_sr_d       = BYTE_W'(UNDERRUN_FILL);
                rd_underrun_d = 1'b1;
              end
              rd_have_d = 1'b0;
              rd_pend_d = 1'b1;
              addr_d    = addr_next_c;
              rd_req_d  = 1'b1;
              rd_addr_d = addr_next_c;
            end else begin
              tx_sr_d = tx_sr_q << 1;
            end
            if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    miso_d = busy_d & tx_sr_d[BYTE_W-1];
  end

  assign miso_pad    = miso_q;
  assign busy        = busy_q;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign rd_underrun = rd_underrun_q;

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench for spi_slave_burst: a mode-0 instance for write bursts and
// reset behaviour, a mode-3 instance for reads with a delayed responder.
module tb_spi_slave_burst;

`ifdef SPI_ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int HALF = 8;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [1:0] csn_pad   = 2'b11;
  logic [1:0] sck_pad   = 2'b10;
  logic       mosi_pad  = 1'b0;

  logic       miso_pad    [2];
  logic       busy        [2];
  logic       wr_valid    [2];
  logic       rd_req      [2];
  logic       rd_underrun [2];
  logic [6:0] wr_addr     [2];
  logic [6:0] rd_addr     [2];
  logic [7:0] wr_data     [2];

  logic       rd_valid_m0 = 1'b0;
  logic [7:0] rd_data_m0  = 8'h00;
  logic       rd_valid_m3 = 1'b0;
  logic [7:0] rd_data_m3  = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  spi_slave_burst #(.BYTE_W(8), .ADDR_W(8), .CPOL(0), .CPHA(0)) u_m0 (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .csn_pad     (csn_pad[0]),
    .sck_pad     (sck_pad[0]),
    .mosi_pad    (mosi_pad),
    .miso_pad    (miso_pad[0]),
    .busy        (busy[0]),
    .wr_valid    (wr_valid[0]),
    .wr_addr     (wr_addr[0]),
    .wr_data     (wr_data[0]),
    .rd_req      (rd_req[0]),
    .rd_addr     (rd_addr[0]),
    .rd_valid    (rd_valid_m0),
    .rd_data     (rd_data_m0),
    .rd_underrun (rd_underrun[0])
  );

  spi_slave_burst #(.BYTE_W(8), .ADDR_W(8), .CPOL(1), .CPHA(1)) u_m3 (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .csn_pad     (csn_pad[1]),
    .sck_pad     (sck_pad[1]),
    .mosi_pad    (mosi_pad),
    .miso_pad    (miso_pad[1]),
    .busy        (busy[1]),
    .wr_valid    (wr_valid[1]),
    .wr_addr     (wr_addr[1]),
    .wr_data     (wr_data[1]),
    .rd_req      (rd_req[1]),
    .rd_addr     (rd_addr[1]),
    .rd_valid    (rd_valid_m3),
    .rd_data     (rd_data_m3),
    .rd_underrun (rd_underrun[1])
  );

  // Output logs, sampled mid-cycle
  int         wr_n       [2];
  int         rq_n       [2];
  int         ur_n       [2];
  int         wr_run     [2];
  int         wr_run_max [2];
  logic [6:0] wr_a_log   [2][32];
  logic [7:0] wr_d_log   [2][32];
  logic [6:0] rq_a_log   [2][32];

  always @(negedge sys_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wr_valid[k]) begin
        if (wr_n[k] < 32) begin
          wr_a_log[k][wr_n[k]] = wr_addr[k];
          wr_d_log[k][wr_n[k]] = wr_data[k];
        end
        wr_n[k]++;
        wr_run[k]++;
        if (wr_run[k] > wr_run_max[k]) wr_run_max[k] = wr_run[k];
      end else begin
        wr_run[k] = 0;
      end
      if (rd_req[k]) begin
        if (rq_n[k] < 32) rq_a_log[k][rq_n[k]] = rd_addr[k];
        rq_n[k]++;
      end
      if (rd_underrun[k]) ur_n[k]++;
    end
  end

  // Fabric model for the mode-3 instance: answers rd_req two cycles later
  bit         resp_en  = 1'b1;
  logic [7:0] resp_val = 8'h5A;
  int         resp_cnt = -1;

  always @(negedge sys_clk) begin
    rd_valid_m3 = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
    end else if (resp_cnt == 0) begin
      if (resp_en) begin
        rd_valid_m3 = 1'b1;
        rd_data_m3  = resp_val;
      end
      resp_cnt = -1;
    end
    if (rd_req[1]) resp_cnt = 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Bit-banged master; m3 selects mode 3 (else mode 0). MSB of tx[nbits-1:0] first.
  task automatic spi_frame(input int idx, input bit m3, input logic [63:0] tx,
                           input int nbits, input bit keep_cs, output logic [63:0] rx);
    rx = '0;
    csn_pad[idx] = 1'b0;
    wait_cyc(HALF);
    check($sformatf("busy_on%0d", idx), 32'(busy[idx]), 32'd1);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!m3) begin
        mosi_pad = tx[i];
        wait_cyc(HALF);
        sck_pad[idx] = 1'b1;
        rx = {rx[62:0], miso_pad[idx]};
        wait_cyc(HALF);
        sck_pad[idx] = 1'b0;
      end else begin
        sck_pad[idx] = 1'b0;
        mosi_pad = tx[i];
        wait_cyc(HALF);
        sck_pad[idx] = 1'b1;
        rx = {rx[62:0], miso_pad[idx]};
        wait_cyc(HALF);
      end
    end
    wait_cyc(HALF);
    if (!keep_cs) begin
      csn_pad[idx] = 1'b1;
      wait_cyc(HALF);
      check($sformatf("busy_off%0d", idx), 32'(busy[idx]), 32'd0);
      check($sformatf("miso_idle%0d", idx), 32'(miso_pad[idx]), 32'd0);
    end
  endtask

  initial begin
    logic [63:0] rx;
    int b0;
    int r0;
    int u0;

    // Reset values
    wait_cyc(3);
    check("rst_miso",     32'(miso_pad[0]),    32'd0);
    check("rst_busy",     32'(busy[0]),        32'd0);
    check("rst_wr_valid", 32'(wr_valid[0]),    32'd0);
    check("rst_rd_req",   32'(rd_req[0]),      32'd0);
    check("rst_underrun", 32'(rd_underrun[0]), 32'd0);
    check("rst_wr_addr",  32'(wr_addr[0]),     32'd0);
    check("rst_wr_data",  32'(wr_data[0]),     32'd0);
    check("rst_rd_addr",  32'(rd_addr[0]),     32'd0);
    sys_rst_n = 1'b1;
    wait_cyc(10);

    // Mode 0 write burst 0x12: A5, 3C
    b0 = wr_n[0];
    spi_frame(0, 1'b0, 64'h12A53C, 24, 1'b0, rx);
    check("wr_count",  32'(wr_n[0] - b0),          32'd2);
    check("wr0_addr",  32'(wr_a_log[0][b0]),       32'h12);
    check("wr0_data",  32'(wr_d_log[0][b0]),       32'hA5);
    check("wr1_addr",  32'(wr_a_log[0][b0 + 1]),   AUTOINC ? 32'h13 : 32'h12);
    check("wr1_data",  32'(wr_d_log[0][b0 + 1]),   32'h3C);

    // Mode 3 read 0x85, fabric returns 0x5A
    r0 = rq_n[1];
    u0 = ur_n[1];
    resp_en = 1'b1;
    spi_frame(1, 1'b1, 64'h8500, 16, 1'b0, rx);
    check("rd_miso",     32'(rx[15:0]),           32'h005A);
    check("rd_req_cnt",  32'(rq_n[1] - r0),       32'd2);
    check("rd_req0",     32'(rq_a_log[1][r0]),    32'h05);
    check("rd_req1",     32'(rq_a_log[1][r0 + 1]), AUTOINC ? 32'h06 : 32'h05);
    check("rd_no_ur",    32'(ur_n[1] - u0),       32'd0);

    // Mode 3 read with no fabric answer: underrun fill
    r0 = rq_n[1];
    u0 = ur_n[1];
    resp_en = 1'b0;
    spi_frame(1, 1'b1, 64'h8500, 16, 1'b0, rx);
    check("ur_miso",     32'(rx[15:0]),     32'h00FF);
    check("ur_count",    32'(ur_n[1] - u0), 32'd1);
    check("ur_req_cnt",  32'(rq_n[1] - r0), 32'd2);
    resp_en = 1'b1;

    // Address wrap at 0x7F
    b0 = wr_n[0];
    spi_frame(0, 1'b0, 64'h7F1122, 24, 1'b0, rx);
    check("wrap_count", 32'(wr_n[0] - b0),        32'd2);
    check("wrap0_addr", 32'(wr_a_log[0][b0]),     32'h7F);
    check("wrap0_data", 32'(wr_d_log[0][b0]),     32'h11);
    check("wrap1_addr", 32'(wr_a_log[0][b0 + 1]), AUTOINC ? 32'h00 : 32'h7F);
    check("wrap1_data", 32'(wr_d_log[0][b0 + 1]), 32'h22);

    // CS rises after 5 data bits, then a normal frame
    b0 = wr_n[0];
    spi_frame(0, 1'b0, 64'h416, 13, 1'b0, rx);
    check("part_no_wr", 32'(wr_n[0] - b0), 32'd0);
    b0 = wr_n[0];
    spi_frame(0, 1'b0, 64'h305C, 16, 1'b0, rx);
    check("next_count", 32'(wr_n[0] - b0),    32'd1);
    check("next_addr",  32'(wr_a_log[0][b0]), 32'h30);
    check("next_data",  32'(wr_d_log[0][b0]), 32'h5C);

    // Reset mid-word with CS held low
    b0 = wr_n[0];
    spi_frame(0, 1'b0, 64'h205, 11, 1'b1, rx);
    sys_rst_n = 1'b0;
    #1;
    check("mid_busy",     32'(busy[0]),        32'd0);
    check("mid_miso",     32'(miso_pad[0]),    32'd0);
    check("mid_wr_valid", 32'(wr_valid[0]),    32'd0);
    check("mid_wr_addr",  32'(wr_addr[0]),     32'd0);
    check("mid_wr_data",  32'(wr_data[0]),     32'd0);
    check("mid_rd_req",   32'(rd_req[0]),      32'd0);
    check("mid_underrun", 32'(rd_underrun[0]), 32'd0);
    check("mid_rd_addr",  32'(rd_addr[0]),     32'd0);
    @(negedge sys_clk);
    wait_cyc(3);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mosi_pad = 1'b1;
      wait_cyc(HALF);
      sck_pad[0] = 1'b1;
      wait_cyc(HALF);
      sck_pad[0] = 1'b0;
    end
    wait_cyc(HALF);
    check("no_restart_busy", 32'(busy[0]),       32'd0);
    check("no_restart_wr",   32'(wr_n[0] - b0),  32'd0);
    csn_pad[0] = 1'b1;
    wait_cyc(2 * HALF);
    b0 = wr_n[0];
    spi_frame(0, 1'b0, 64'h0199, 16, 1'b0, rx);
    check("post_rst_count", 32'(wr_n[0] - b0),    32'd1);
    check("post_rst_addr",  32'(wr_a_log[0][b0]), 32'h01);
    check("post_rst_data",  32'(wr_d_log[0][b0]), 32'h99);

    check("wr_valid_width", 32'(wr_run_max[0]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
